// File: rtl/evt_packetiser_pkg.sv
// Shared constants and helpers for the event packetiser: packet field
// positions, field widths and the default microsecond divider.
package evt_packetiser_pkg;

  localparam int PKT_BITS    = 72;
  localparam int DSSFT_BITS  = 5;

  localparam int KEY_BITS    = 32;
  localparam int PLD_BITS    = 32;
  localparam int EVT_BITS    = 32;

  localparam int PKT_PAR_BIT = 0;
  localparam int PKT_LNG_BIT = 1;
  localparam int PKT_KEY_BIT = 8;
  localparam int PKT_PLD_BIT = 40;

  localparam int US_CLK_CNT_DEF = 74;

  localparam logic [3:0] KEEP_ALL = 4'b1111;

  // Contents of stage A: everything needed to build a packet later.
  typedef struct packed {
    logic                lng;
    logic [PLD_BITS-1:0] pld;
    logic [KEY_BITS-1:0] key;
  } stage_a_t;

  // Assemble a packet with the parity bit left clear.
  function automatic logic [PKT_BITS-1:0] build_pkt(
    input logic [KEY_BITS-1:0] key,
    input logic [PLD_BITS-1:0] pld,
    input logic                lng
  );
    logic [PKT_BITS-1:0] p;
    p                           = '0;
    p[PKT_KEY_BIT +: KEY_BITS]  = key;
    p[PKT_PLD_BIT +: PLD_BITS]  = pld;
    p[PKT_LNG_BIT]              = lng;
    p[PKT_PAR_BIT]              = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/evt_packetiser_parity_gen.sv
// Odd-parity generator for an assembled packet. The input must have its
// parity bit clear; the output is the value that bit must take so the full
// word carries an odd number of ones.
module pkt_parity_gen
  import evt_packetiser_pkg::*;
(
  input  logic [PKT_BITS-1:0] pkt_i,
  output logic                par_o
);

  assign par_o = ~^pkt_i;

endmodule

// File: rtl/evt_packetiser.sv
// Event packetiser: turns AXI-stream peripheral events into multicast
// packets through a two-deep pipeline (stage A = key/payload, stage B =
// output register with parity). A held packet that the transmitter refuses
// for drop_wait_in stalled cycles is discarded and reported on
// inp_drp_cnt_out.
//
// Optional build macro: TIMESTAMP_PLD_EN
//   defined   - long packets carrying a per-frame microsecond timestamp
//   undefined - short packets, evt_last_in unused, no timestamp logic
module evt_packetiser
  import evt_packetiser_pkg::*;
#(
  parameter int US_CLK_CNT = US_CLK_CNT_DEF,
  parameter int WAIT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic [EVT_BITS-1:0]   evt_data_in,
  input  logic [3:0]            evt_keep_in,
  input  logic                  evt_last_in,
  input  logic                  evt_vld_in,
  output logic                  evt_rdy_out,

  input  logic [KEY_BITS-1:0]   mp_key_in,
  input  logic [KEY_BITS-1:0]   mp_msk_in,
  input  logic [DSSFT_BITS-1:0] mp_sft_in,
  input  logic [WAIT_BITS-1:0]  drop_wait_in,

  output logic [PKT_BITS-1:0]   pkt_data_out,
  output logic                  pkt_vld_out,
  input  logic                  pkt_rdy_in,

  output logic                  inp_drp_cnt_out
);

  logic                 run_q;
  logic                 a_vld_q, a_vld_d;
  stage_a_t             a_q, a_d;
  logic                 b_vld_q, b_vld_d;
  logic [PKT_BITS-1:0]  b_pkt_q, b_pkt_d;
  logic [WAIT_BITS-1:0] wcnt_q, wcnt_d;

  logic                 stall;
  logic                 drop_now;
  logic                 b_free;
  logic                 b_load;
  logic                 evt_acc;
  logic                 evt_good;
  logic                 evt_rej;
  logic [KEY_BITS-1:0]  key_map;
  logic [PLD_BITS-1:0]  evt_pld;
  logic                 evt_lng;
  logic [PKT_BITS-1:0]  pkt_raw;
  logic                 pkt_par;

  assign stall    = b_vld_q && !pkt_rdy_in;
  // Expiry only fires while still stalled, so a late pkt_rdy_in wins.
  assign drop_now = stall && (wcnt_q == WAIT_BITS'(1)) && (drop_wait_in != '0);
  assign b_free   = !b_vld_q || pkt_rdy_in || drop_now;
  assign b_load   = a_vld_q && b_free;

  assign evt_rdy_out = run_q && (!a_vld_q || b_free);
  assign evt_acc     = evt_vld_in && evt_rdy_out;
  assign evt_good    = evt_acc && (evt_keep_in == KEEP_ALL);
  assign evt_rej     = evt_acc && (evt_keep_in != KEEP_ALL);

  assign key_map = mp_key_in | ((evt_data_in & mp_msk_in) >> mp_sft_in);

`ifdef TIMESTAMP_PLD_EN
  logic [31:0] cyc_q;
  logic [31:0] us_q;
  logic [31:0] ts_q;
  logic        sof_q;

  // Free-running microsecond time base.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      us_q  <= '0;
    end else if (cyc_q == 32'(US_CLK_CNT)) begin
      cyc_q <= '0;
      us_q  <= us_q + 32'd1;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  // Latch the time at the first event of each frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q  <= '0;
      sof_q <= 1'b1;
    end else if (evt_acc) begin
      if (sof_q) ts_q <= us_q;
      sof_q <= evt_last_in;
    end
  end

  // The frame's first event uses the live value, which is what ts_q latches.
  assign evt_pld = sof_q ? us_q : ts_q;
  assign evt_lng = 1'b1;
`else
  logic unused_ok;

  assign evt_pld   = '0;
  assign evt_lng   = 1'b0;
  assign unused_ok = ^{evt_last_in, 32'(US_CLK_CNT)};
`endif

  assign pkt_raw = build_pkt(a_q.key, a_q.pld, a_q.lng);

  pkt_parity_gen u_parity (
    .pkt_i (pkt_raw),
    .par_o (pkt_par)
  );

  // Run flag: keeps the input closed during reset and the first cycle after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Stage A: capture a good event, empty when its contents move into B.
  always_comb begin
    a_vld_d = a_vld_q;
    a_d     = a_q;
    if (evt_good) begin
      a_vld_d = 1'b1;
      a_d.key = key_map;
      a_d.pld = evt_pld;
      a_d.lng = evt_lng;
    end else if (b_load) begin
      a_vld_d = 1'b0;
    end
  end

  // Stage B and drop watchdog: load from A, release on transfer or drop.
  always_comb begin
    b_vld_d = b_vld_q;
    b_pkt_d = b_pkt_q;
    wcnt_d  = wcnt_q;
    if (b_load) begin
      b_vld_d = 1'b1;
      b_pkt_d = pkt_raw | PKT_BITS'(pkt_par);
      wcnt_d  = drop_wait_in;
    end else begin
      if (b_free) b_vld_d = 1'b0;
      if (stall && (wcnt_q != '0)) wcnt_d = wcnt_q - WAIT_BITS'(1);
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld_q <= 1'b0;
      a_q     <= '0;
      b_vld_q <= 1'b0;
      b_pkt_q <= '0;
      wcnt_q  <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      a_q     <= a_d;
      b_vld_q <= b_vld_d;
      b_pkt_q <= b_pkt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pkt_data_out    = b_pkt_q;
  assign pkt_vld_out     = b_vld_q;
  // A reject and a drop in the same cycle merge into one pulse.
  assign inp_drp_cnt_out = evt_rej || drop_now;

endmodule

// File: tb/tb_evt_packetiser.sv
module tb_evt_packetiser;
  import evt_packetiser_pkg::*;

  localparam int WB = 16;
`ifdef TIMESTAMP_PLD_EN
  localparam logic LNG = 1'b1;
`else
  localparam logic LNG = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [31:0]           evt_data_in = '0;
  logic [3:0]            evt_keep_in = '0;
  logic                  evt_last_in = 1'b0;
  logic                  evt_vld_in = 1'b0;
  logic                  evt_rdy_out;
  logic [31:0]           mp_key_in = '0;
  logic [31:0]           mp_msk_in = '0;
  logic [DSSFT_BITS-1:0] mp_sft_in = '0;
  logic [WB-1:0]         drop_wait_in = '0;
  logic [PKT_BITS-1:0]   pkt_data_out;
  logic                  pkt_vld_out;
  logic                  pkt_rdy_in = 1'b0;
  logic                  inp_drp_cnt_out;

  always #5 clk = ~clk;

  evt_packetiser #(.US_CLK_CNT(74), .WAIT_BITS(WB)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .evt_data_in     (evt_data_in),
    .evt_keep_in     (evt_keep_in),
    .evt_last_in     (evt_last_in),
    .evt_vld_in      (evt_vld_in),
    .evt_rdy_out     (evt_rdy_out),
    .mp_key_in       (mp_key_in),
    .mp_msk_in       (mp_msk_in),
    .mp_sft_in       (mp_sft_in),
    .drop_wait_in    (drop_wait_in),
    .pkt_data_out    (pkt_data_out),
    .pkt_vld_out     (pkt_vld_out),
    .pkt_rdy_in      (pkt_rdy_in),
    .inp_drp_cnt_out (inp_drp_cnt_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]           data;
    logic [3:0]            keep;
    logic [31:0]           base;
    logic [31:0]           msk;
    logic [DSSFT_BITS-1:0] sft;
    logic [31:0]           exp_key;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] sb[$];
  logic [31:0] pld_log[$];
  int          pulses = 0;
  int          exp_pulses = 0;
  int          drops_seen = 0;
  int          run_len = 0;
  int          max_run = 0;
  longint      cyc = 0;
  longint      last_pop = -10;
  logic [31:0] exp_k;

  function automatic logic [31:0] model_key(input logic [31:0] d, input logic [31:0] b,
                                            input logic [31:0] m, input logic [DSSFT_BITS-1:0] s);
    return b | ((d & m) >> s);
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: every transfer or drop is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (inp_drp_cnt_out) pulses++;
      if (pkt_vld_out && (pkt_rdy_in || inp_drp_cnt_out)) begin
        chk("pkt_expected", 72'(sb.size() != 0), 72'(1));
        if (sb.size() != 0) begin
          exp_k = sb.pop_front();
          chk("pkt_key", 72'(pkt_data_out[39:8]), 72'(exp_k));
          chk("pkt_hdr", 72'(pkt_data_out[7:1]), 72'({6'b0, LNG}));
          chk("pkt_parity", 72'(^pkt_data_out), 72'(1));
`ifndef TIMESTAMP_PLD_EN
          chk("pkt_pld_zero", 72'(pkt_data_out[71:40]), 72'(0));
`endif
        end
        if (pkt_rdy_in) begin
          pld_log.push_back(pkt_data_out[71:40]);
          if (cyc == last_pop + 1) run_len++;
          else run_len = 1;
          last_pop = cyc;
          if (run_len > max_run) max_run = run_len;
        end else begin
          drops_seen++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] data, input logic [3:0] keep, input logic last,
                      input logic [31:0] ekey);
    bit ok;
    evt_data_in = data;
    evt_keep_in = keep;
    evt_last_in = last;
    evt_vld_in  = 1'b1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (evt_rdy_out) ok = 1;
      @(posedge clk); #1;
    end
    chk("send_accept", 72'(ok), 72'(1));
    if (ok) begin
      if (keep == 4'b1111) sb.push_back(ekey);
      else exp_pulses++;
    end
  endtask

  task automatic cfg(input vec_t v);
    mp_key_in = v.base;
    mp_msk_in = v.msk;
    mp_sft_in = v.sft;
  endtask

  task automatic idle(input int n);
    evt_vld_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    bit stable;
    logic [PKT_BITS-1:0] held;
    logic [31:0] p0;

    vecs[0] = '{32'h000ABCD5, 4'hF, 32'h12340000, 32'h0000FFF0, 5'd4,  32'h12340BCD};
    vecs[1] = '{32'h00000001, 4'hF, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000001};
    vecs[2] = '{32'hAB123456, 4'hF, 32'h00000000, 32'hFF000000, 5'd24, 32'h000000AB};
    vecs[3] = '{32'h1234567C, 4'hF, 32'hFFFF0000, 32'h0000000F, 5'd0,  32'hFFFF000C};
    vecs[4] = '{32'h00000300, 4'hF, 32'h00000100, 32'h00000F00, 5'd8,  32'h00000103};
    vecs[5] = '{32'h80000000, 4'hF, 32'h00000000, 32'hFFFFFFFF, 5'd31, 32'h00000001};
    vecs[6] = '{32'hDEADBEEF, 4'b0011, 32'h11111111, 32'hFFFFFFFF, 5'd0, 32'h0};
    vecs[7] = '{32'hFFFFFFFF, 4'hF, 32'h5A5A5A5A, 32'h00000000, 5'd0,  32'h5A5A5A5A};

    // Reset values
    @(negedge clk);
    chk("rst_vld", 72'(pkt_vld_out), 72'(0));
    chk("rst_data", pkt_data_out, 72'(0));
    chk("rst_rdy", 72'(evt_rdy_out), 72'(0));
    chk("rst_drp", 72'(inp_drp_cnt_out), 72'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_first_cycle", 72'(evt_rdy_out), 72'(0));
    @(negedge clk);
    chk("rdy_running", 72'(evt_rdy_out), 72'(1));
    @(posedge clk); #1;

    // Mapping and latency
    pkt_rdy_in = 1'b1;
    cfg(vecs[0]);
    send(vecs[0].data, vecs[0].keep, 1'b0, vecs[0].exp_key);
    evt_vld_in = 1'b0;
    @(negedge clk);
    chk("latency_n1", 72'(pkt_vld_out), 72'(0));
    @(negedge clk);
    chk("latency_n2", 72'(pkt_vld_out), 72'(1));
    chk("map_key", 72'(pkt_data_out[39:8]), 72'(32'h12340BCD));
    @(posedge clk); #1;
    idle(3);

    // Table of mappings including a partial word
    for (int i = 1; i < 8; i++) begin
      int p_before;
      p_before = pulses;
      cfg(vecs[i]);
      send(vecs[i].data, vecs[i].keep, 1'b0, vecs[i].exp_key);
      idle(4);
      chk("vec_drained", 72'(sb.size()), 72'(0));
      chk("vec_pulses", 72'(pulses - p_before), 72'(vecs[i].keep == 4'hF ? 0 : 1));
    end

    // Back-to-back, sink always ready
    cfg(vecs[0]);
    max_run = 0;
    n = pulses;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = 32'h00010000 + 32'(i) * 32'h00000130;
      send(d, 4'hF, 1'b0, model_key(d, vecs[0].base, vecs[0].msk, vecs[0].sft));
    end
    idle(5);
    chk("b2b_consecutive", 72'(max_run), 72'(8));
    chk("b2b_drained", 72'(sb.size()), 72'(0));
    chk("b2b_no_drop", 72'(pulses - n), 72'(0));

    // Drop after 5 stalled cycles, next packet presented
    pkt_rdy_in   = 1'b0;
    drop_wait_in = 16'd5;
    cfg(vecs[1]);
    send(32'h00000011, 4'hF, 1'b0, 32'h80000011);
    send(32'h00000022, 4'hF, 1'b0, 32'h80000022);
    evt_vld_in = 1'b0;
    exp_pulses++;
    n = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (pkt_vld_out) n++;
      if (inp_drp_cnt_out) got = 1;
    end
    chk("drop_seen", 72'(got), 72'(1));
    chk("drop_hold_cycles", 72'(n), 72'(5));
    @(negedge clk);
    chk("drop_next_vld", 72'(pkt_vld_out), 72'(1));
    chk("drop_next_key", 72'(pkt_data_out[39:8]), 72'(32'h80000022));
    @(posedge clk); #1;
    pkt_rdy_in = 1'b1;
    idle(3);
    chk("drop_count", 72'(drops_seen), 72'(1));
    chk("drop_drained", 72'(sb.size()), 72'(0));

    // No drop when wait is zero; input closes once A is full
    pkt_rdy_in   = 1'b0;
    drop_wait_in = '0;
    send(32'h00000033, 4'hF, 1'b0, 32'h80000033);
    send(32'h00000044, 4'hF, 1'b0, 32'h80000044);
    evt_vld_in = 1'b0;
    @(negedge clk);
    held = pkt_data_out;
    stable = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!pkt_vld_out || pkt_data_out !== held || evt_rdy_out || inp_drp_cnt_out) stable = 0;
    end
    chk("hold_forever", 72'(stable), 72'(1));
    chk("hold_key", 72'(held[39:8]), 72'(32'h80000033));
    chk("rdy_low_full", 72'(evt_rdy_out), 72'(0));
    @(posedge clk); #1;
    pkt_rdy_in = 1'b1;
    idle(4);
    chk("hold_drained", 72'(sb.size()), 72'(0));

    // Reset while B is stalled
    pkt_rdy_in = 1'b0;
    send(32'h00000055, 4'hF, 1'b0, 32'h80000055);
    send(32'h00000066, 4'hF, 1'b0, 32'h80000066);
    evt_vld_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_vld", 72'(pkt_vld_out), 72'(0));
    chk("midrst_rdy", 72'(evt_rdy_out), 72'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pkt_rdy_in = 1'b1;
    n = int'(pld_log.size());
    send(32'h00000077, 4'hF, 1'b1, 32'h80000077);
    idle(4);
    chk("midrst_one_pkt", 72'(pld_log.size() - n), 72'(1));
    chk("midrst_drained", 72'(sb.size()), 72'(0));

`ifdef TIMESTAMP_PLD_EN
    // Frame of 3 events spread over more than 2 us, then a later frame
    pld_log.delete();
    send(32'h00000101, 4'hF, 1'b0, 32'h80000101);
    idle(100);
    send(32'h00000102, 4'hF, 1'b0, 32'h80000102);
    idle(100);
    send(32'h00000103, 4'hF, 1'b1, 32'h80000103);
    idle(160);
    send(32'h00000104, 4'hF, 1'b1, 32'h80000104);
    idle(4);
    chk("ts_pkts", 72'(pld_log.size()), 72'(4));
    if (pld_log.size() == 4) begin
      p0 = pld_log[0];
      chk("ts_same_1", 72'(pld_log[1]), 72'(p0));
      chk("ts_same_2", 72'(pld_log[2]), 72'(p0));
      chk("ts_advance", 72'(pld_log[3] >= p0 + 32'd2), 72'(1));
    end
`endif

    chk("drop_pulses_total", 72'(pulses), 72'(exp_pulses));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
